maxpool_window_buffer: RTL

- Upstream feeder for the 2x2 max-pool comparator.
- Accepts a feature map streamed one pixel per handshake in raster order (row 0 col 0 first).
- Buffers one row and emits non-overlapping 2x2 windows (stride 2) on a registered valid/ready output that drives the comparator input matrix directly.

---
 rtl/maxpool_window_buffer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/maxpool_window_buffer.sv
// maxpool_window_buffer: collects a raster-order pixel stream into non-overlapping
// 2x2 windows (stride 2) for the max-pool comparator.
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  : upstream pixel handshake (in_ready is combinational)
//   in_data            : unsigned pixel
//   win_valid/win_ready: registered window handshake toward the comparator
//   win                : [row][col] window, [0][*] upper row, [*][0] left column
//   win_last           : marks the final window of a frame
//   frame_done         : one-cycle pulse after the final window is consumed
module maxpool_window_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 28,
  parameter int unsigned IMG_HEIGHT = 28
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             in_ready,
  output logic                             win_valid,
  output logic [1:0][1:0][DATA_WIDTH-1:0]  win,
  input  logic                             win_ready,
  output logic                             win_last,
  output logic                             frame_done
);

  localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  // Geometry must tile exactly into 2x2 windows.
  if ((IMG_WIDTH < 2) || ((IMG_WIDTH % 2) != 0)) begin : g_bad_width
    $error("maxpool_window_buffer: IMG_WIDTH must be even and >= 2");
  end
  if ((IMG_HEIGHT < 2) || ((IMG_HEIGHT % 2) != 0)) begin : g_bad_height
    $error("maxpool_window_buffer: IMG_HEIGHT must be even and >= 2");
  end

  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [COL_W-1:0]        col;
  logic [ROW_W-1:0]        row;
  logic [DATA_WIDTH-1:0]   hold;
  logic [DATA_WIDTH-1:0]   line_buf [IMG_WIDTH];
  logic                    accept;
  logic                    col_end;
  logic                    row_end;
  logic                    load;

  // Upstream may advance whenever the window slot is empty or being drained.
  always_comb begin
    in_ready = !win_valid || win_ready;
    accept   = in_valid && in_ready;
    col_end  = (col == COL_LAST);
    row_end  = (row == ROW_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ROW_EVEN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state follows row parity; odd-column pixels of odd rows close a window.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ROW_EVEN: begin
        if (accept && col_end) state_nxt = ROW_ODD;
      end
      ROW_ODD: begin
        load = accept && col[0];
        if (accept && col_end) state_nxt = ROW_EVEN;
      end
      default: state_nxt = ROW_EVEN;
    endcase
  end

  // Upper row of each window pair; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept && (state == ROW_EVEN)) begin
      line_buf[col] <= in_data;
    end
  end

  // Raster counters, lower-left hold pixel and the window output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      win        <= '0;
      win_valid  <= 1'b0;
      win_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= win_valid && win_ready && win_last;

      if (accept) begin
        col <= col_end ? '0 : col + COL_W'(1);
        if (col_end) begin
          row <= row_end ? '0 : row + ROW_W'(1);
        end
        if ((state == ROW_ODD) && !col[0]) begin
          hold <= in_data;
        end
      end

      // A load on the consuming edge replaces the old window without a bubble.
      if (load) begin
        win[0][0] <= line_buf[col - COL_W'(1)];
        win[0][1] <= line_buf[col];
        win[1][0] <= hold;
        win[1][1] <= in_data;
        win_valid <= 1'b1;
        win_last  <= row_end && col_end;
      end else if (win_valid && win_ready) begin
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end
    end
  end

endmodule
